// File: rtl/io_disp_pkg.sv
// rtl/io_disp_pkg.sv - shared digit codes, segment patterns and FSM encoding for the 7-segment scanner
package io_disp_pkg;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  // Double-dabble correction applied before each shift
  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational digit code to active-low 7-segment pattern
module seg7_decode
  import io_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (code)
      4'd0:     seg_n = SEG_0;
      4'd1:     seg_n = SEG_1;
      4'd2:     seg_n = SEG_2;
      4'd3:     seg_n = SEG_3;
      4'd4:     seg_n = SEG_4;
      4'd5:     seg_n = SEG_5;
      4'd6:     seg_n = SEG_6;
      4'd7:     seg_n = SEG_7;
      4'd8:     seg_n = SEG_8;
      4'd9:     seg_n = SEG_9;
      DIG_DASH: seg_n = SEG_DASH;
      default:  seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/io_seg7_scan.sv
// rtl/io_seg7_scan.sv - three output ports to two decimal digits each, scanned onto a 6-digit display
module io_seg7_scan
  import io_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n,
  output logic        dp_n,
  output logic [2:0]  bcd_valid
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [1:0]       state;
  logic [1:0]       sel;
  logic [14:0]      dd;
  logic [2:0]       cnt;
  logic             ovf;
  logic [5:0][3:0]  digits;
  logic [31:0]      port_val;
  logic [3:0]       st_tens;
  logic [3:0]       st_ones;
  logic [PW-1:0]    presc;
  logic [2:0]       idx;
  logic [3:0]       cur_code;
  logic [6:0]       cur_seg;

  always_comb begin
    port_val = out_port0;
    case (sel)
      2'd1:    port_val = out_port1;
      2'd2:    port_val = out_port2;
      default: port_val = out_port0;
    endcase
  end

  assign st_tens = ovf ? DIG_DASH : dd[14:11];
  assign st_ones = ovf ? DIG_DASH : dd[10:7];

  // dd holds {bcd[7:0], sh[6:0]} so one shift moves the binary MSB into the BCD LSB
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      sel       <= 2'd0;
      dd        <= '0;
      cnt       <= 3'd0;
      ovf       <= 1'b0;
      digits    <= {6{DIG_BLANK}};
      bcd_valid <= 3'b000;
    end else begin
      case (state)
        S_IDLE: state <= S_LOAD;
        S_LOAD: begin
          ovf   <= (port_val > 32'd99);
          dd    <= {8'h00, port_val[6:0]};
          cnt   <= 3'd0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          dd  <= {bcd_adjust(dd[14:7]), dd[6:0]} << 1;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) state <= S_STORE;
        end
        S_STORE: begin
          case (sel)
            2'd0: begin
              digits[1:0]  <= {st_tens, st_ones};
              bcd_valid[0] <= 1'b1;
            end
            2'd1: begin
              digits[3:2]  <= {st_tens, st_ones};
              bcd_valid[1] <= 1'b1;
            end
            default: begin
              digits[5:4]  <= {st_tens, st_ones};
              bcd_valid[2] <= 1'b1;
            end
          endcase
          sel   <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_code = DIG_BLANK;
    case (idx)
      3'd0:    cur_code = digits[0];
      3'd1:    cur_code = digits[1];
      3'd2:    cur_code = digits[2];
      3'd3:    cur_code = digits[3];
      3'd4:    cur_code = digits[4];
      3'd5:    cur_code = digits[5];
      default: cur_code = DIG_BLANK;
    endcase
  end

  seg7_decode u_decode (
    .code  (cur_code),
    .seg_n (cur_seg)
  );

  // Both digits of a port change on the same edge, so one registered sample never mixes old and new
  always_ff @(posedge clock) begin
    if (!resetn) begin
      presc <= '0;
      idx   <= 3'd0;
      seg_n <= SEG_OFF;
      an_n  <= 6'h3F;
      dp_n  <= 1'b1;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      an_n  <= ~(6'b1 << idx);
      seg_n <= cur_seg;
      dp_n  <= !((idx == 3'd2) || (idx == 3'd4));
    end
  end

endmodule
